// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Loads per-pad configuration words into the daisy-chained GPIO control
//   blocks. A snapshot of the flat cfg_words bus is shifted out MSB first,
//   one bit per 2*CLK_DIV clk cycles. serial_clock is low for the first half
//   of each bit and high for the second half. The chain's parallel-load
//   strobe is then pulsed for CLK_DIV cycles, and done pulses for one cycle.
//
//   Optional feature macro: GPIO_LOADER_AUTOSTART_EN
//     When this macro is defined, one internal start request fires on the
//     second clk edge after reset release. When it is not defined, transfers
//     begin only from the start port.
//
//   All outputs come straight from flops. The active-low async reset returns
//   every output to its idle value immediately.

module gpio_serial_loader #(
  parameter int NUM_GPIO  = 19,
  parameter int CFG_WIDTH = 13,
  parameter int CLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [NUM_GPIO*CFG_WIDTH-1:0] cfg_words,
  output logic                          busy,
  output logic                          done,
  output logic                          serial_clock,
  output logic                          serial_data,
  output logic                          serial_load,
  output logic                          serial_resetn
);

  localparam int TOTAL   = NUM_GPIO * CFG_WIDTH;
  localparam int BIT_W   = $clog2(TOTAL + 1);
  localparam int PHASE_W = $clog2(CLK_DIV + 1);

  // Exact terminal counts. Counters clear on state entry and never wrap.
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(TOTAL - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [PHASE_W-1:0] phase_cnt;   // cycles spent in the current clock phase
  logic [BIT_W-1:0]   bit_cnt;     // bits completed in the current transfer
  logic [TOTAL-1:0]   shift_reg;   // snapshot of cfg_words, MSB goes out first

  logic start_eff;   // start port, or the one-shot auto-start
  logic accept;      // start request is taken this cycle
  logic phase_end;   // last cycle of the current serial_clock phase
  logic bit_end;     // last cycle of the high phase, so the bit is complete
  logic last_bit;    // the bit in flight is the final one

  logic busy_d;
  logic done_d;
  logic sclk_d;
  logic load_d;

`ifdef GPIO_LOADER_AUTOSTART_EN
  logic auto_fired;

  // auto_fired trails serial_resetn by one edge. Together they open a
  // one-cycle window that is sampled on the second edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      auto_fired <= 1'b0;
    end else begin
      auto_fired <= serial_resetn;
    end
  end

  assign start_eff = start | (serial_resetn & ~auto_fired);
`else
  assign start_eff = start;
`endif

  // A start request is only taken while busy is low. That includes the
  // single DONE cycle, which allows back-to-back loads.
  assign accept    = start_eff && ((state == ST_IDLE) || (state == ST_DONE));
  assign phase_end = (phase_cnt == PHASE_LAST);
  assign bit_end   = (state == ST_SHIFT) && phase_end && serial_clock;
  assign last_bit  = (bit_cnt == BIT_LAST);

  // The chain comes out of reset on the first edge after our own reset is released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      serial_resetn <= 1'b0;
    end else begin
      serial_resetn <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking, so all flops update
      // together from values taken before the edge, whatever the order of the statements.
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: assign a default before the case. Then every path assigns
    // next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      ST_IDLE:  if (accept) next_state = ST_SHIFT;
      ST_SHIFT: if (bit_end && last_bit) next_state = ST_LOAD;
      ST_LOAD:  if (phase_end) next_state = ST_DONE;
      ST_DONE:  next_state = accept ? ST_SHIFT : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Phase and bit counters and the shift register. Both counters clear on
  // every state change, so each state starts counting from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
      // NOTE: shift_reg is a data register, but its MSB drives serial_data
      // directly. It is reset so that serial_data is 0 in reset and a
      // partial transfer is discarded when reset is asserted.
      shift_reg <= '0;
    end else begin
      if (next_state != state) begin
        phase_cnt <= '0;
        bit_cnt   <= '0;
      end else if ((state == ST_SHIFT) || (state == ST_LOAD)) begin
        phase_cnt <= phase_end ? '0 : phase_cnt + PHASE_W'(1);
        if (bit_end) begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end

      // The snapshot is taken on the accepting edge. Later changes to
      // cfg_words do not reach the chain until the next load. Zeros shift
      // in behind the data, so serial_data is 0 once every bit has gone out.
      if (accept) begin
        shift_reg <= cfg_words;
      end else if (bit_end) begin
        shift_reg <= {shift_reg[TOTAL-2:0], 1'b0};
      end
    end
  end

  assign serial_data = shift_reg[TOTAL-1];

  // Output decode. This computes the next value of each registered output
  // from the state being entered.
  always_comb begin
    busy_d = (next_state == ST_SHIFT) || (next_state == ST_LOAD);
    done_d = (next_state == ST_DONE);
    load_d = (next_state == ST_LOAD);
    sclk_d = 1'b0;
    // Each new bit starts low. The level toggles at the end of each phase.
    // The edge that completes a bit therefore drops the clock as the next
    // data bit is presented.
    if ((state == ST_SHIFT) && (next_state == ST_SHIFT)) begin
      sclk_d = phase_end ? ~serial_clock : serial_clock;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_load  <= 1'b0;
    end else begin
      busy         <= busy_d;
      done         <= done_d;
      serial_clock <= sclk_d;
      serial_load  <= load_d;
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader
//   Directed bench for gpio_serial_loader. It drives two instances:
//     u_small : NUM_GPIO=2, CLK_DIV=1 (26-bit chain). Every bit is checked.
//     u_big   : default parameters (247-bit chain, CLK_DIV=4). Timing and
//               the captured chain contents are checked.
//   Inputs change on the falling edge and outputs are sampled on the
//   falling edge. Either instance sees start on the next rising edge.

module tb_gpio_serial_loader;

  localparam int S_TOT = 26;
  localparam int B_TOT = 247;

  logic clk = 1'b0;
  logic resetn;

  logic             start_s;
  logic [S_TOT-1:0] cfg_s;
  logic             busy_s, done_s, sclk_s, sdata_s, sload_s, srst_s;

  logic             start_b;
  logic [B_TOT-1:0] cfg_b;
  logic             busy_b, done_b, sclk_b, sdata_b, sload_b, srst_b;

  int total = 0;
  int bad   = 0;

  gpio_serial_loader #(
    .NUM_GPIO (2),
    .CFG_WIDTH(13),
    .CLK_DIV  (1)
  ) u_small (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start_s),
    .cfg_words    (cfg_s),
    .busy         (busy_s),
    .done         (done_s),
    .serial_clock (sclk_s),
    .serial_data  (sdata_s),
    .serial_load  (sload_s),
    .serial_resetn(srst_s)
  );

  gpio_serial_loader u_big (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start_b),
    .cfg_words    (cfg_b),
    .busy         (busy_b),
    .done         (done_b),
    .serial_clock (sclk_b),
    .serial_data  (sdata_b),
    .serial_load  (sload_b),
    .serial_resetn(srst_b)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic checkn(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Checks one complete small-instance transfer. Entry: the falling edge just
  // after the accepting edge. Exit: the falling edge just after done rises.
  // With poke set, cfg_s is changed mid-transfer and start is pulsed while
  // busy. Neither may affect the transfer.
  task automatic xfer_small(input logic [S_TOT-1:0] exp, input bit poke, input string tag);
    for (int i = S_TOT - 1; i >= 0; i--) begin
      check1({tag, "_busy"}, busy_s, 1'b1);
      check1({tag, "_sclk_lo"}, sclk_s, 1'b0);
      check1({tag, "_bit_lo"}, sdata_s, exp[i]);
      if (poke && i == 20) cfg_s = ~cfg_s;
      if (poke && i == 15) start_s = 1'b1;
      if (poke && i == 14) start_s = 1'b0;
      tick();
      check1({tag, "_sclk_hi"}, sclk_s, 1'b1);
      check1({tag, "_bit_hi"}, sdata_s, exp[i]);
      check1({tag, "_noload"}, sload_s, 1'b0);
      tick();
    end
    check1({tag, "_load_on"}, sload_s, 1'b1);
    check1({tag, "_load_sclk"}, sclk_s, 1'b0);
    check1({tag, "_load_busy"}, busy_s, 1'b1);
    check1({tag, "_load_nodone"}, done_s, 1'b0);
    tick();
    check1({tag, "_done"}, done_s, 1'b1);
    check1({tag, "_done_busy"}, busy_s, 1'b0);
    check1({tag, "_load_off"}, sload_s, 1'b0);
  endtask

  initial begin
    logic [B_TOT-1:0] cap;
    logic [31:0]      hi_nonzero;
    int               cycles;
    int               nbits;
    int               busy_cnt;
    int               loads;
    int               dones_s;
    int               dones_b;
    logic             prev_sclk;

    resetn  = 1'b0;
    start_s = 1'b0;
    start_b = 1'b0;
    cfg_s   = '0;
    cfg_b   = '0;

    // ---- reset values ----
    #1;
    check1("rst_busy", busy_s, 1'b0);
    check1("rst_done", done_s, 1'b0);
    check1("rst_sclk", sclk_s, 1'b0);
    check1("rst_sdata", sdata_s, 1'b0);
    check1("rst_load", sload_s, 1'b0);
    check1("rst_srst", srst_s, 1'b0);
    check1("rst_big_busy", busy_b, 1'b0);
    check1("rst_big_srst", srst_b, 1'b0);

    @(negedge clk);
    resetn = 1'b1;
    #1;
    check1("rel_srst_low", srst_s, 1'b0);
    tick();
    check1("rel_srst_high", srst_s, 1'b1);
    check1("rel_big_srst_high", srst_b, 1'b1);
    check1("rel_busy", busy_s, 1'b0);

    // ---- auto-start behaviour (or its absence) ----
`ifdef GPIO_LOADER_AUTOSTART_EN
    tick();
    check1("auto_busy_s", busy_s, 1'b1);
    check1("auto_busy_b", busy_b, 1'b1);
    dones_s = 0;
    dones_b = 0;
    for (int c = 0; c < 2100; c++) begin
      tick();
      if (done_s) dones_s++;
      if (done_b) dones_b++;
    end
    checkn("auto_dones_s", 32'(dones_s), 32'd1);
    checkn("auto_dones_b", 32'(dones_b), 32'd1);
    check1("auto_idle_s", busy_s, 1'b0);
    check1("auto_idle_b", busy_b, 1'b0);
`else
    for (int c = 0; c < 4; c++) begin
      tick();
      check1("noauto_busy_s", busy_s, 1'b0);
      check1("noauto_busy_b", busy_b, 1'b0);
    end
`endif

    // ---- alternating pattern, with cfg change and start pulse mid-transfer ----
    cfg_s   = 26'h2AAAAAA;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    xfer_small(26'h2AAAAAA, 1'b1, "alt");
    for (int c = 0; c < 4; c++) begin
      tick();
      check1("alt_after_done", done_s, 1'b0);
      check1("alt_after_busy", busy_s, 1'b0);
      check1("alt_after_sdata", sdata_s, 1'b0);
    end

    // ---- start held through DONE: back-to-back transfers ----
    cfg_s   = 26'h1234567;
    start_s = 1'b1;
    tick();
    xfer_small(26'h1234567, 1'b0, "held1");
    cfg_s = 26'h30F0F0F;
    tick();
    start_s = 1'b0;
    check1("held_done_fell", done_s, 1'b0);
    xfer_small(26'h30F0F0F, 1'b0, "held2");
    tick();
    check1("held_idle", busy_s, 1'b0);

    // ---- default instance: pad0 = 13'h0402, others 0 ----
    cfg_b        = '0;
    cfg_b[12:0]  = 13'h0402;
    start_b      = 1'b1;
    tick();
    start_b = 1'b0;
    check1("big_busy0", busy_b, 1'b1);
    check1("big_sclk0", sclk_b, 1'b0);
    cap       = '0;
    nbits     = 0;
    busy_cnt  = 1;
    loads     = 0;
    cycles    = 0;
    prev_sclk = sclk_b;
    while (done_b !== 1'b1 && cycles < 3000) begin
      start_b = (cycles == 10 || cycles == 500) ? 1'b1 : 1'b0;
      if (cycles == 100) cfg_b = '1;
      tick();
      cycles++;
      if (sclk_b && !prev_sclk) begin
        cap = {cap[B_TOT-2:0], sdata_b};
        nbits++;
      end
      prev_sclk = sclk_b;
      if (busy_b) busy_cnt++;
      if (sload_b) loads++;
    end
    start_b = 1'b0;
    checkn("big_done_cycle", 32'(cycles), 32'd1980);
    checkn("big_busy_cycles", 32'(busy_cnt), 32'd1980);
    checkn("big_load_cycles", 32'(loads), 32'd4);
    checkn("big_nbits", 32'(nbits), 32'd247);
    checkn("big_last13", {19'd0, cap[12:0]}, 32'h0402);
    hi_nonzero = {31'd0, |cap[B_TOT-1:13]};
    checkn("big_upper_zero", hi_nonzero, 32'd0);
    check1("big_done_busy", busy_b, 1'b0);
    dones_b = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_b) dones_b++;
    end
    checkn("big_single_done", 32'(dones_b), 32'd0);
    check1("big_idle", busy_b, 1'b0);

    // ---- reset in the middle of a transfer ----
    cfg_s   = 26'h155AA33;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    check1("mid_busy_before", busy_s, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check1("mid_busy", busy_s, 1'b0);
    check1("mid_done", done_s, 1'b0);
    check1("mid_sclk", sclk_s, 1'b0);
    check1("mid_sdata", sdata_s, 1'b0);
    check1("mid_load", sload_s, 1'b0);
    check1("mid_srst", srst_s, 1'b0);
    check1("mid_big_srst", srst_b, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check1("mid_no_done", done_s, 1'b0);
    end
    cfg_s   = 26'h2C0FFEE;
    start_s = 1'b1;
    resetn  = 1'b1;
    tick();
    start_s = 1'b0;
    check1("mid_rel_srst", srst_s, 1'b1);
    xfer_small(26'h2C0FFEE, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
